npc_ctrl: RTL and testbench
===========================

Name: npc_ctrl

Overview:
- Next-PC control generator; the producer side of the NPCOp/Adress interface consumed by the PC unit.
- Decodes the current instruction and register operands, then resolves branches and jumps.
- Implements the MIPS one-instruction branch delay slot by holding a pending redirect for one cycle.
- Drives link-register write info for jal/jalr to the register file.

Parameters:
- DELAY_SLOT, 1, 1 = MIPS delay-slot semantics; 0 = redirect issued in the same cycle as the control instruction.
- LINK_REG, 31, destination register index for jal.

Ports:
- clk  input  1  clock; state updates on posedge (PC unit updates on negedge of same clock)
- PcReSet  input  1  asynchronous, active-high reset
- Hold  input  1  stall; freeze PC and controller state
- Instr  input  32  instruction at current PC
- PC  input  32  current PC from PC unit
- RsData  input  32  register file rs read value
- RtData  input  32  register file rt read value
- NPCOp  output  2  00 PC+4, 01 absolute Adress, 10 jump {PC[31:28],Adress[25:0],00}, 11 hold
- Adress  output  32  redirect target / jump index
- LinkWe  output  1  link write enable
- LinkDst  output  5  link destination register
- LinkAddr  output  32  return address
- SlotErr  output  1  sticky; control transfer seen in a delay slot

Behaviour:
- Reset (async, while PcReSet=1): state=SEQ, pending op/target=0, SlotErr=0; outputs forced NPCOp=00, Adress=0, LinkWe=0, LinkDst=0, LinkAddr=0.
- Decoded ops:
  - beq: op 000100, taken iff RsData==RtData.
  - bne: op 000101, taken iff RsData!=RtData.
  - j: op 000010.
  - jal: op 000011.
  - jr: op 0, funct 001000.
  - jalr: op 0, funct 001001.
  - All other instructions are sequential.
- Targets (32-bit, wrap-around):
  - Branch: PC+4+(signext(Instr[15:0])<<2), NPCOp=01.
  - j/jal: Adress={6'b0,Instr[25:0]}, NPCOp=10.
  - jr/jalr: Adress=RsData, NPCOp=01.
- States: SEQ, SLOT.
- SEQ, Hold=1: NPCOp=11, LinkWe=0, no state change.
- SEQ, no taken transfer: NPCOp=00, Adress=0.
- SEQ, taken transfer:
  - DELAY_SLOT=1: NPCOp=00; at posedge, latch pending op/target and go to SLOT.
  - DELAY_SLOT=0: drive target op/Adress directly and stay in SEQ.
- Not-taken branch: NPCOp=00 and remain in SEQ. A not-taken branch still opens a delay slot only in the sense of sequential flow, so no state change.
- SLOT: NPCOp/Adress = pending values.
  - At posedge with Hold=0: go to SEQ.
  - With Hold=1: NPCOp=11, stay in SLOT, pending values retained.
- Control transfer decoded in SLOT: its redirect is dropped, its link write is suppressed, and SlotErr is set at posedge. Cleared only by reset.
- Link (jal/jalr, decoded in SEQ, Hold=0):
  - LinkWe=1 combinationally.
  - LinkDst = LINK_REG for jal, Instr[15:11] for jalr.
  - LinkAddr = PC+8 (DELAY_SLOT=1) or PC+4 (DELAY_SLOT=0).
- Otherwise LinkWe=0.
- Reset mid-SLOT: pending redirect is discarded.

Optional Feature:
- Macro: NPC_BRANCH_EXT_EN.
- Defined: adds the following branches, using a signed compare on RsData, with the same target rule and delay-slot handling as beq/bne:
  - bltz: op 000001, rt=00000.
  - bgez: op 000001, rt=00001.
  - blez: op 000110.
  - bgtz: op 000111.
- Undefined: these opcodes decode as sequential (NPCOp=00).

Decomposition:
- Package npc_pkg:
  - NPCOp constants: NPC_SEQ=00, NPC_ABS=01, NPC_JMP=10, NPC_HOLD=11.
  - Opcode and funct constants.
  - State enum {SEQ, SLOT}.
- Sub-module npc_branch_eval (combinational): inputs Instr, PC, RsData, RtData; outputs taken, op, target, is_link, is_ctrl.
- Top level holds the FSM, pending registers and SlotErr.

Test Plan:
- Taken beq: PC=0x00400000, beq imm=0x0003, RsData=RtData=5 -> cycle0 NPCOp=00; cycle1 NPCOp=01, Adress=0x00400010; cycle2 NPCOp=00.
- Not-taken bne: bne, RsData=RtData=7 -> NPCOp=00 both cycles; state stays SEQ.
- jal: PC=0x00400008, jal index 0x0100040 -> cycle0 LinkWe=1, LinkDst=31, LinkAddr=0x00400010; cycle1 NPCOp=10, Adress=0x00100040.
- Hold in SLOT: jr with RsData=0x00400100, Hold=1 for 2 cycles in SLOT -> NPCOp=11 for both; on release NPCOp=01, Adress=0x00400100.
- Slot violation: j followed by beq (taken) in slot -> only j redirect issued; SlotErr=1 after posedge, stays 1.
- Reset mid-SLOT: assert PcReSet during SLOT -> NPCOp=00, Adress=0, SlotErr=0 immediately; after release state is SEQ with no pending redirect.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: shared constants and types for the next-PC controller.
//   - NPCOp encodings driven to the PC unit
//   - MIPS opcode / funct / REGIMM rt field values
//   - controller state enum
//   - branch_target(): PC-relative branch target helper
package npc_pkg;

  localparam logic [1:0] NPC_SEQ  = 2'b00;  // PC + 4
  localparam logic [1:0] NPC_ABS  = 2'b01;  // absolute Adress
  localparam logic [1:0] NPC_JMP  = 2'b10;  // {PC[31:28], Adress[25:0], 00}
  localparam logic [1:0] NPC_HOLD = 2'b11;  // keep PC

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  typedef enum logic {SEQ = 1'b0, SLOT = 1'b1} state_t;

  // PC + 4 + (signext(imm) << 2), 32-bit wrap-around.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_branch_eval.sv
// npc_branch_eval: combinational decode and resolution of one instruction.
// Ports:
//   Instr, PC, RsData, RtData : instruction, its PC and register operands
//   taken    : instruction redirects control flow
//   op       : NPCOp encoding for the redirect
//   target   : redirect target (branch/jr) or jump index (j/jal)
//   is_link  : jal / jalr
//   is_ctrl  : any branch or jump, taken or not
// Build option: NPC_BRANCH_EXT_EN adds bltz/bgez/blez/bgtz (signed compare on RsData).
import npc_pkg::*;

module npc_branch_eval (
  input  logic [31:0] Instr,
  input  logic [31:0] PC,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  output logic        taken,
  output logic [1:0]  op,
  output logic [31:0] target,
  output logic        is_link,
  output logic        is_ctrl
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] br_tgt;
  logic        rs_neg;
  logic        rs_zero;
  logic        unused_bits;

  assign opcode  = Instr[31:26];
  assign funct   = Instr[5:0];
  assign br_tgt  = branch_target(PC, Instr[15:0]);
  assign rs_neg  = RsData[31];
  assign rs_zero = (RsData == 32'd0);
  // shamt and rt-index fields do not steer any decision here
  assign unused_bits = ^{Instr[10:6], Instr[20:16], rs_neg, rs_zero};

  always_comb begin
    taken   = 1'b0;
    op      = NPC_SEQ;
    target  = 32'd0;
    is_link = 1'b0;
    is_ctrl = 1'b0;
    case (opcode)
      OP_BEQ: begin
        is_ctrl = 1'b1;
        taken   = (RsData == RtData);
        op      = NPC_ABS;
        target  = br_tgt;
      end
      OP_BNE: begin
        is_ctrl = 1'b1;
        taken   = (RsData != RtData);
        op      = NPC_ABS;
        target  = br_tgt;
      end
      OP_J, OP_JAL: begin
        is_ctrl = 1'b1;
        taken   = 1'b1;
        op      = NPC_JMP;
        target  = {6'b0, Instr[25:0]};
        is_link = (opcode == OP_JAL);
      end
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          is_ctrl = 1'b1;
          taken   = 1'b1;
          op      = NPC_ABS;
          target  = RsData;
          is_link = (funct == FN_JALR);
        end
      end
`ifdef NPC_BRANCH_EXT_EN
      OP_REGIMM: begin
        if (Instr[20:16] == RT_BLTZ || Instr[20:16] == RT_BGEZ) begin
          is_ctrl = 1'b1;
          taken   = (Instr[20:16] == RT_BLTZ) ? rs_neg : !rs_neg;
          op      = NPC_ABS;
          target  = br_tgt;
        end
      end
      OP_BLEZ: begin
        is_ctrl = 1'b1;
        taken   = rs_neg || rs_zero;
        op      = NPC_ABS;
        target  = br_tgt;
      end
      OP_BGTZ: begin
        is_ctrl = 1'b1;
        taken   = !rs_neg && !rs_zero;
        op      = NPC_ABS;
        target  = br_tgt;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/npc_ctrl.sv
// npc_ctrl: next-PC control generator feeding the PC unit.
// Ports:
//   clk, PcReSet (async active-high), Hold (stall)
//   Instr, PC, RsData, RtData : current instruction and operands
//   NPCOp, Adress             : redirect command to the PC unit
//   LinkWe, LinkDst, LinkAddr : jal/jalr return-address write
//   SlotErr                   : sticky, control transfer seen in a delay slot
// Parameters: DELAY_SLOT (1 = one-instruction delay slot), LINK_REG (jal dest).
// Build option: NPC_BRANCH_EXT_EN (see npc_branch_eval).
import npc_pkg::*;

module npc_ctrl #(
  parameter bit         DELAY_SLOT = 1'b1,
  parameter logic [4:0] LINK_REG   = 5'd31
) (
  input  logic        clk,
  input  logic        PcReSet,
  input  logic        Hold,
  input  logic [31:0] Instr,
  input  logic [31:0] PC,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  output logic [1:0]  NPCOp,
  output logic [31:0] Adress,
  output logic        LinkWe,
  output logic [4:0]  LinkDst,
  output logic [31:0] LinkAddr,
  output logic        SlotErr
);

  state_t      state_q, state_d;
  logic [1:0]  pend_op_q, pend_op_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        slot_err_q, slot_err_d;

  logic        br_taken;
  logic [1:0]  br_op;
  logic [31:0] br_target;
  logic        br_is_link;
  logic        br_is_ctrl;

  npc_branch_eval u_eval (
    .Instr   (Instr),
    .PC      (PC),
    .RsData  (RsData),
    .RtData  (RtData),
    .taken   (br_taken),
    .op      (br_op),
    .target  (br_target),
    .is_link (br_is_link),
    .is_ctrl (br_is_ctrl)
  );

  always_comb begin
    state_d    = state_q;
    pend_op_d  = pend_op_q;
    pend_tgt_d = pend_tgt_q;
    slot_err_d = slot_err_q;
    NPCOp      = NPC_SEQ;
    Adress     = 32'd0;
    LinkWe     = 1'b0;
    LinkDst    = 5'd0;
    LinkAddr   = 32'd0;

    case (state_q)
      SEQ: begin
        if (Hold) begin
          NPCOp = NPC_HOLD;
        end else begin
          if (br_is_link) begin
            LinkWe   = 1'b1;
            LinkDst  = (Instr[31:26] == OP_JAL) ? LINK_REG : Instr[15:11];
            LinkAddr = DELAY_SLOT ? (PC + 32'd8) : (PC + 32'd4);
          end
          if (br_taken) begin
            if (DELAY_SLOT) begin
              // slot instruction executes first; redirect goes out next cycle
              pend_op_d  = br_op;
              pend_tgt_d = br_target;
              state_d    = SLOT;
            end else begin
              NPCOp  = br_op;
              Adress = br_target;
            end
          end
        end
      end
      SLOT: begin
        Adress = pend_tgt_q;
        if (Hold) begin
          NPCOp = NPC_HOLD;
        end else begin
          NPCOp      = pend_op_q;
          state_d    = SEQ;
          pend_op_d  = NPC_SEQ;
          pend_tgt_d = 32'd0;
          // a branch/jump sitting in the slot is ignored, only flagged
          if (br_is_ctrl) slot_err_d = 1'b1;
        end
      end
      default: state_d = SEQ;
    endcase

    // outputs are forced quiet for the whole reset pulse, not just at the edge
    if (PcReSet) begin
      NPCOp    = NPC_SEQ;
      Adress   = 32'd0;
      LinkWe   = 1'b0;
      LinkDst  = 5'd0;
      LinkAddr = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge PcReSet) begin
    if (PcReSet) begin
      state_q    <= SEQ;
      pend_op_q  <= NPC_SEQ;
      pend_tgt_q <= 32'd0;
      slot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_op_q  <= pend_op_d;
      pend_tgt_q <= pend_tgt_d;
      slot_err_q <= slot_err_d;
    end
  end

  assign SlotErr = slot_err_q;

endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl: directed self-checking bench for npc_ctrl (DELAY_SLOT=1).
// Inputs change 1 time unit after posedge; outputs are checked 2 units later.
`timescale 1ns/1ps
module tb_npc_ctrl;

  logic        clk;
  logic        PcReSet;
  logic        Hold;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic [1:0]  NPCOp;
  logic [31:0] Adress;
  logic        LinkWe;
  logic [4:0]  LinkDst;
  logic [31:0] LinkAddr;
  logic        SlotErr;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] BEQ_P3   = 32'h1022_0003; // beq r1,r2,+3
  localparam logic [31:0] BEQ_M2   = 32'h1022_FFFE; // beq r1,r2,-2
  localparam logic [31:0] BNE_P3   = 32'h1422_0003; // bne r1,r2,+3
  localparam logic [31:0] JAL_IDX  = 32'h0C10_0040; // jal 0x0100040
  localparam logic [31:0] J_IDX    = 32'h0800_0100; // j 0x0000100
  localparam logic [31:0] JR_R1    = 32'h0020_0008; // jr r1
  localparam logic [31:0] JALR_R5  = 32'h0020_2809; // jalr r5, r1
  localparam logic [31:0] BLTZ_R1  = 32'h0420_0005; // bltz r1,+5

  npc_ctrl #(.DELAY_SLOT(1'b1), .LINK_REG(5'd31)) dut (
    .clk      (clk),
    .PcReSet  (PcReSet),
    .Hold     (Hold),
    .Instr    (Instr),
    .PC       (PC),
    .RsData   (RsData),
    .RtData   (RtData),
    .NPCOp    (NPCOp),
    .Adress   (Adress),
    .LinkWe   (LinkWe),
    .LinkDst  (LinkDst),
    .LinkAddr (LinkAddr),
    .SlotErr  (SlotErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      failures_cnt++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
    end
  endtask

  // apply one instruction cycle's inputs and let them settle
  task automatic drive(input logic [31:0] i, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt, input logic h);
    Instr = i; PC = pc; RsData = rs; RtData = rt; Hold = h;
    #2;
    $display("txn t=%0t instr=%08h pc=%08h hold=%0b -> npcop=%0d adress=%08h linkwe=%0b dst=%0d laddr=%08h slot_err=%0b",
             $time, i, pc, h, NPCOp, Adress, LinkWe, LinkDst, LinkAddr, SlotErr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    PcReSet = 1'b1;
    drive(JAL_IDX, 32'h0040_0008, 32'd0, 32'd0, 1'b0);
    check("rst_npcop", {30'd0, NPCOp}, 32'd0);
    check("rst_adress", Adress, 32'd0);
    check("rst_linkwe", {31'd0, LinkWe}, 32'd0);
    check("rst_linkdst", {27'd0, LinkDst}, 32'd0);
    check("rst_linkaddr", LinkAddr, 32'd0);
    check("rst_sloterr", {31'd0, SlotErr}, 32'd0);
    tick(); tick();
    PcReSet = 1'b0;

    // taken beq
    drive(BEQ_P3, 32'h0040_0000, 32'd5, 32'd5, 1'b0);
    check("beq_c0_npcop", {30'd0, NPCOp}, 32'd0);
    check("beq_c0_linkwe", {31'd0, LinkWe}, 32'd0);
    tick();
    drive(NOP, 32'h0040_0004, 32'd0, 32'd0, 1'b0);
    check("beq_c1_npcop", {30'd0, NPCOp}, 32'd1);
    check("beq_c1_adress", Adress, 32'h0040_0010);
    tick();
    drive(NOP, 32'h0040_0010, 32'd0, 32'd0, 1'b0);
    check("beq_c2_npcop", {30'd0, NPCOp}, 32'd0);
    tick();

    // not-taken bne
    drive(BNE_P3, 32'h0040_0010, 32'd7, 32'd7, 1'b0);
    check("bne_c0_npcop", {30'd0, NPCOp}, 32'd0);
    tick();
    drive(NOP, 32'h0040_0014, 32'd0, 32'd0, 1'b0);
    check("bne_c1_npcop", {30'd0, NPCOp}, 32'd0);
    check("bne_c1_adress", Adress, 32'd0);
    tick();

    // jal, first under Hold (no link write, NPCOp hold), then released
    drive(JAL_IDX, 32'h0040_0008, 32'd0, 32'd0, 1'b1);
    check("jal_hold_npcop", {30'd0, NPCOp}, 32'd3);
    check("jal_hold_linkwe", {31'd0, LinkWe}, 32'd0);
    tick();
    drive(JAL_IDX, 32'h0040_0008, 32'd0, 32'd0, 1'b0);
    check("jal_c0_npcop", {30'd0, NPCOp}, 32'd0);
    check("jal_c0_linkwe", {31'd0, LinkWe}, 32'd1);
    check("jal_c0_linkdst", {27'd0, LinkDst}, 32'd31);
    check("jal_c0_linkaddr", LinkAddr, 32'h0040_0010);
    tick();
    drive(NOP, 32'h0040_000C, 32'd0, 32'd0, 1'b0);
    check("jal_c1_npcop", {30'd0, NPCOp}, 32'd2);
    check("jal_c1_adress", Adress, 32'h0010_0040);
    check("jal_c1_linkwe", {31'd0, LinkWe}, 32'd0);
    tick();

    // jr with two held cycles in the slot
    drive(JR_R1, 32'h0010_0040, 32'h0040_0100, 32'd0, 1'b0);
    check("jr_c0_npcop", {30'd0, NPCOp}, 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(NOP, 32'h0010_0044, 32'd0, 32'd0, 1'b1);
      check("jr_hold_npcop", {30'd0, NPCOp}, 32'd3);
      tick();
    end
    drive(NOP, 32'h0010_0044, 32'd0, 32'd0, 1'b0);
    check("jr_rel_npcop", {30'd0, NPCOp}, 32'd1);
    check("jr_rel_adress", Adress, 32'h0040_0100);
    tick();
    drive(NOP, 32'h0040_0100, 32'd0, 32'd0, 1'b0);
    check("jr_after_npcop", {30'd0, NPCOp}, 32'd0);
    tick();

    // jalr: rd from Instr[15:11], return address PC+8
    drive(JALR_R5, 32'h0040_0100, 32'h0040_0200, 32'd0, 1'b0);
    check("jalr_linkwe", {31'd0, LinkWe}, 32'd1);
    check("jalr_linkdst", {27'd0, LinkDst}, 32'd5);
    check("jalr_linkaddr", LinkAddr, 32'h0040_0108);
    tick();
    drive(NOP, 32'h0040_0104, 32'd0, 32'd0, 1'b0);
    check("jalr_c1_adress", Adress, 32'h0040_0200);
    tick();

    // negative offset wrapping below address zero
    drive(BEQ_M2, 32'h0000_0000, 32'd9, 32'd9, 1'b0);
    tick();
    drive(NOP, 32'h0000_0004, 32'd0, 32'd0, 1'b0);
    check("wrap_npcop", {30'd0, NPCOp}, 32'd1);
    check("wrap_adress", Adress, 32'hFFFF_FFFC);
    tick();

    // bltz with negative rs: taken only with the extension enabled
    drive(BLTZ_R1, 32'h0040_0000, 32'h8000_0000, 32'd0, 1'b0);
    tick();
    drive(NOP, 32'h0040_0004, 32'd0, 32'd0, 1'b0);
`ifdef NPC_BRANCH_EXT_EN
    check("bltz_npcop", {30'd0, NPCOp}, 32'd1);
    check("bltz_adress", Adress, 32'h0040_0018);
`else
    check("bltz_npcop", {30'd0, NPCOp}, 32'd0);
    check("bltz_adress", Adress, 32'd0);
`endif
    tick();

    // slot violation: j then taken beq in its slot
    drive(J_IDX, 32'h0040_0020, 32'd0, 32'd0, 1'b0);
    tick();
    drive(BEQ_P3, 32'h0040_0024, 32'd3, 32'd3, 1'b0);
    check("slot_npcop", {30'd0, NPCOp}, 32'd2);
    check("slot_adress", Adress, 32'h0000_0100);
    check("slot_err_pre", {31'd0, SlotErr}, 32'd0);
    tick();
    drive(NOP, 32'h0000_0400, 32'd0, 32'd0, 1'b0);
    check("slot_beq_dropped", {30'd0, NPCOp}, 32'd0);
    check("slot_err_set", {31'd0, SlotErr}, 32'd1);
    tick();
    drive(NOP, 32'h0000_0404, 32'd0, 32'd0, 1'b0);
    check("slot_beq_dropped2", {30'd0, NPCOp}, 32'd0);
    check("slot_err_sticky", {31'd0, SlotErr}, 32'd1);
    tick();

    // reset while in SLOT
    drive(J_IDX, 32'h0000_0408, 32'd0, 32'd0, 1'b0);
    tick();
    drive(NOP, 32'h0000_040C, 32'd0, 32'd0, 1'b0);
    check("rslot_pre_npcop", {30'd0, NPCOp}, 32'd2);
    PcReSet = 1'b1;
    #1;
    check("rslot_npcop", {30'd0, NPCOp}, 32'd0);
    check("rslot_adress", Adress, 32'd0);
    check("rslot_sloterr", {31'd0, SlotErr}, 32'd0);
    tick();
    PcReSet = 1'b0;
    drive(NOP, 32'h0000_040C, 32'd0, 32'd0, 1'b0);
    check("rslot_after_npcop", {30'd0, NPCOp}, 32'd0);
    check("rslot_after_adress", Adress, 32'd0);
    tick();
    drive(NOP, 32'h0000_0410, 32'd0, 32'd0, 1'b0);
    check("rslot_after2_npcop", {30'd0, NPCOp}, 32'd0);
    check("rslot_after2_sloterr", {31'd0, SlotErr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
